// File: rtl/pad_bank_ctrl_pkg.sv
// Shared types for the bidirectional pad bank.
// Pin direction states and IOBUF T encodings.
package pad_pkg;

    typedef enum logic [1:0] {
        S_IN,
        S_TA,
        S_OUT
    } pad_state_e;

    localparam logic PAD_T_INPUT  = 1'b1;
    localparam logic PAD_T_OUTPUT = 1'b0;

endpackage

// File: rtl/pad_bank_ctrl_if.sv
// Core-side and pad-side signals of one pad bank.
// slave = the controller, master = core logic plus pads.
interface pad_bank_ctrl_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] core_o;
    logic [WIDTH-1:0] core_t;
    logic [WIDTH-1:0] core_i;
    logic [WIDTH-1:0] core_busy;
    logic [WIDTH-1:0] edge_rise;
    logic [WIDTH-1:0] edge_fall;
    logic [WIDTH-1:0] pad_o;
    logic [WIDTH-1:0] pad_t;
    logic [WIDTH-1:0] pad_i;

    modport master (
        output core_o, core_t, pad_i,
        input  core_i, core_busy, edge_rise, edge_fall,
        input  pad_o, pad_t
    );

    modport slave (
        input  core_o, core_t, pad_i,
        output core_i, core_busy, edge_rise, edge_fall,
        output pad_o, pad_t
    );

endinterface

// File: rtl/pad_bank_ctrl_cell.sv
// One pad pin: direction FSM with turnaround, output register,
// input synchroniser and masked edge detection.
module pad_cell_ctrl
    import pad_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TURNAROUND    = 1,
    parameter bit REG_OUT       = 1'b1,
    parameter bit EDGE_MASK_OUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic core_o_i,
    input  logic core_t_i,
    input  logic pad_i_i,
    output logic core_i_o,
    output logic core_busy_o,
    output logic edge_rise_o,
    output logic edge_fall_o,
    output logic pad_o_o,
    output logic pad_t_o
);

    localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
    localparam int MW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] TA_LOAD =
        TW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [MW-1:0] MASK_LOAD = MW'(SYNC_STAGES);

    pad_state_e             state_q;
    logic [TW-1:0]          cnt_q;
    logic                   pad_t_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   masked;
    logic                   cur;

    // pad_t is registered from the next state so release is glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IN;
            cnt_q   <= '0;
            pad_t_q <= PAD_T_INPUT;
        end else begin
            unique case (state_q)
                S_IN: begin
                    if (!core_t_i) begin
                        if (TURNAROUND == 0) begin
                            state_q <= S_OUT;
                            pad_t_q <= PAD_T_OUTPUT;
                        end else begin
                            state_q <= S_TA;
                            cnt_q   <= TA_LOAD;
                        end
                    end
                end
                S_TA: begin
                    if (core_t_i) begin
                        state_q <= S_IN;
                    end else if (cnt_q == '0) begin
                        state_q <= S_OUT;
                        pad_t_q <= PAD_T_OUTPUT;
                    end else begin
                        cnt_q <= cnt_q - TW'(1);
                    end
                end
                S_OUT: begin
                    if (core_t_i) begin
                        state_q <= S_IN;
                        pad_t_q <= PAD_T_INPUT;
                    end
                end
                default: begin
                    state_q <= S_IN;
                    pad_t_q <= PAD_T_INPUT;
                end
            endcase
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic pad_o_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) pad_o_q <= 1'b0;
            else     pad_o_q <= core_o_i;
        end
        assign pad_o_o = pad_o_q;
    end else begin : g_comb_out
        assign pad_o_o = core_o_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Hide loopback of our own drive until it has left the synchroniser
    if (EDGE_MASK_OUT) begin : g_mask
        logic [MW-1:0] mask_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                  mask_q <= '0;
            else if (state_q != S_IN) mask_q <= MASK_LOAD;
            else if (mask_q != '0)    mask_q <= mask_q - MW'(1);
        end
        assign masked = (state_q != S_IN) || (mask_q != '0);
    end else begin : g_nomask
        assign masked = 1'b0;
    end

    assign cur         = sync_q[SYNC_STAGES-1];
    assign core_i_o    = cur;
    assign core_busy_o = (state_q == S_TA);
    assign pad_t_o     = pad_t_q;
    assign edge_rise_o = cur & ~prev_q & ~masked;
    assign edge_fall_o = ~cur & prev_q & ~masked;

endmodule

// File: rtl/pad_bank_ctrl.sv
// Bank of independent bidirectional pad controllers.
// Checks parameters and replicates one cell per pin.
module pad_bank_ctrl
    import pad_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int TURNAROUND    = 1,
    parameter bit REG_OUT       = 1'b1,
    parameter bit EDGE_MASK_OUT = 1'b1
) (
    input logic        clk,
    input logic        reset,
    pad_bank_ctrl_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("pad_bank_ctrl: WIDTH out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pad_bank_ctrl: SYNC_STAGES out of range");
    end
    if (TURNAROUND < 0 || TURNAROUND > 15) begin : g_bad_ta
        $error("pad_bank_ctrl: TURNAROUND out of range");
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        pad_cell_ctrl #(
            .SYNC_STAGES   (SYNC_STAGES),
            .TURNAROUND    (TURNAROUND),
            .REG_OUT       (REG_OUT),
            .EDGE_MASK_OUT (EDGE_MASK_OUT)
        ) u_cell (
            .clk         (clk),
            .rst         (reset),
            .core_o_i    (bus.core_o[g]),
            .core_t_i    (bus.core_t[g]),
            .pad_i_i     (bus.pad_i[g]),
            .core_i_o    (bus.core_i[g]),
            .core_busy_o (bus.core_busy[g]),
            .edge_rise_o (bus.edge_rise[g]),
            .edge_fall_o (bus.edge_fall[g]),
            .pad_o_o     (bus.pad_o[g]),
            .pad_t_o     (bus.pad_t[g])
        );
    end

endmodule
